shop_port_arb: RTL and testbench

Round-robin arbiter and sequencer that shares the single command port of the `shop_v` database between `NUM_TERM` independent user terminals. A terminal is granted the port for a whole transaction, i.e. a sequence of ASCII tokens such as "Login", "Adm", "123". The block drives `i_rdy` and `i_a` of `shop_v` one token at a time, samples `o_a` after a fixed settle delay, and routes each response back to the owning terminal. It sits between the terminal front-ends and `shop_v` at the top level.

---
 rtl/shop_port_arb_if.sv | 32 +++
 rtl/shop_port_arb.sv | 193 +++++++++++++++++++
 tb/tb_shop_port_arb.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shop_port_arb_if.sv
// Signal bundle between shop_port_arb, the user terminals and the shop_v command port.
// slave: the arbiter itself; master: terminal front-ends plus the shop driving it.
interface shop_port_arb_if #(
   parameter int NUM_TERM     = 4,
   parameter int A_NUM_BITS   = 56,
   parameter int O_A_NUM_BITS = 72,
   parameter int U_NUM_BITS   = 4
);
   logic [NUM_TERM-1:0]            i_req;
   logic [NUM_TERM-1:0]            i_valid;
   logic [NUM_TERM-1:0]            i_last;
   logic [NUM_TERM*A_NUM_BITS-1:0] i_tok;
   logic [NUM_TERM-1:0]            o_grant;
   logic [NUM_TERM-1:0]            o_ack;
   logic [O_A_NUM_BITS-1:0]        o_resp;
   logic [NUM_TERM-1:0]            o_resp_vld;
   logic                           o_timeout;
   logic                           o_shop_rdy;
   logic [A_NUM_BITS-1:0]          o_shop_a;
   logic [U_NUM_BITS-1:0]          o_shop_u;
   logic [O_A_NUM_BITS-1:0]        i_shop_a;

   modport slave (
      input  i_req, i_valid, i_last, i_tok, i_shop_a,
      output o_grant, o_ack, o_resp, o_resp_vld, o_timeout, o_shop_rdy, o_shop_a, o_shop_u
   );

   modport master (
      output i_req, i_valid, i_last, i_tok, i_shop_a,
      input  o_grant, o_ack, o_resp, o_resp_vld, o_timeout, o_shop_rdy, o_shop_a, o_shop_u
   );
endinterface

// File: rtl/shop_port_arb.sv
// Round-robin session arbiter/sequencer sharing the shop_v command port among NUM_TERM terminals.
// Optional idle-session timeout is enabled by defining SHOP_PORT_ARB_TIMEOUT_EN.
module shop_port_arb #(
   parameter int NUM_TERM     = 4,
   parameter int A_NUM_BITS   = 56,
   parameter int O_A_NUM_BITS = 72,
   parameter int U_NUM_BITS   = 4,
   parameter int RESP_WAIT    = 2
`ifdef SHOP_PORT_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT      = 16
`endif
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   shop_port_arb_if.slave bus
);
   localparam int IDX_W = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;

   typedef enum logic [1:0] {IDLE, WAIT_TOK, ISSUE, RESP} state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [NUM_TERM-1:0]     grant_q, grant_d;
   logic [NUM_TERM-1:0]     ack_q, ack_d;
   logic [NUM_TERM-1:0]     resp_vld_q, resp_vld_d;
   logic [U_NUM_BITS-1:0]   shop_u_q, shop_u_d;
   logic [A_NUM_BITS-1:0]   shop_a_q, shop_a_d;
   logic [O_A_NUM_BITS-1:0] resp_q, resp_d;
   logic                    last_q, last_d;
   logic                    rdy_q, rdy_d;
   logic [3:0]              wait_cnt_q, wait_cnt_d;
   logic                    release_s;
   logic [IDX_W-1:0]        pick_idx, owner_inc;
   logic [IDX_W-1:0]        cand_idx [NUM_TERM];
   logic                    owner_req, owner_valid;

`ifdef SHOP_PORT_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             timeout_q, timeout_d;
   assign bus.o_timeout = timeout_q;
`else
   assign bus.o_timeout = 1'b0;
`endif

   // cand_idx[gi] is the terminal checked gi-th, starting at rr_ptr and wrapping.
   for (genvar gi = 0; gi < NUM_TERM; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, rr_ptr_q} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_TERM)) ? IDX_W'(sum - (IDX_W+1)'(NUM_TERM))
                                                           : sum[IDX_W-1:0];
   end

   always_comb begin
      pick_idx = '0;
      for (int i = NUM_TERM - 1; i >= 0; i--) begin
         if (bus.i_req[cand_idx[i]]) pick_idx = cand_idx[i];
      end
   end

   assign owner_inc   = (owner_q == IDX_W'(NUM_TERM - 1)) ? '0 : owner_q + 1'b1;
   assign owner_req   = bus.i_req[owner_q];
   assign owner_valid = bus.i_valid[owner_q];

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      grant_d    = grant_q;
      shop_u_d   = shop_u_q;
      shop_a_d   = shop_a_q;
      last_d     = last_q;
      resp_d     = resp_q;
      wait_cnt_d = wait_cnt_q;
      ack_d      = '0;
      resp_vld_d = '0;
      rdy_d      = 1'b0;
      release_s  = 1'b0;
`ifdef SHOP_PORT_ARB_TIMEOUT_EN
      tmo_cnt_d  = tmo_cnt_q;
      timeout_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (|bus.i_req) begin
               owner_d  = pick_idx;
               grant_d  = NUM_TERM'(1) << pick_idx;
               shop_u_d = U_NUM_BITS'(pick_idx);
               state_d  = WAIT_TOK;
`ifdef SHOP_PORT_ARB_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end
         end
         WAIT_TOK: begin
            // A dropped request wins over a token presented in the same cycle.
            if (!owner_req) begin
               release_s = 1'b1;
            end else if (owner_valid) begin
               shop_a_d = bus.i_tok[owner_q*A_NUM_BITS +: A_NUM_BITS];
               last_d   = bus.i_last[owner_q];
               ack_d    = grant_q;
               state_d  = ISSUE;
            end
`ifdef SHOP_PORT_ARB_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
               release_s = 1'b1;
               timeout_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         ISSUE: begin
            rdy_d      = 1'b1;
            wait_cnt_d = '0;
            state_d    = RESP;
         end
         RESP: begin
            // Count starts on the cycle o_shop_rdy is high, so capture lands RESP_WAIT after its fall.
            if (wait_cnt_q == 4'(RESP_WAIT)) begin
               resp_d     = bus.i_shop_a;
               resp_vld_d = grant_q;
               if (last_q) begin
                  release_s = 1'b1;
               end else begin
                  state_d = WAIT_TOK;
`ifdef SHOP_PORT_ARB_TIMEOUT_EN
                  tmo_cnt_d = '0;
`endif
               end
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (release_s) begin
         grant_d  = '0;
         shop_u_d = '0;
         rr_ptr_d = owner_inc;
         state_d  = IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         grant_q    <= '0;
         shop_u_q   <= '0;
         shop_a_q   <= '0;
         last_q     <= 1'b0;
         resp_q     <= '0;
         wait_cnt_q <= '0;
         ack_q      <= '0;
         resp_vld_q <= '0;
         rdy_q      <= 1'b0;
`ifdef SHOP_PORT_ARB_TIMEOUT_EN
         tmo_cnt_q  <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         grant_q    <= grant_d;
         shop_u_q   <= shop_u_d;
         shop_a_q   <= shop_a_d;
         last_q     <= last_d;
         resp_q     <= resp_d;
         wait_cnt_q <= wait_cnt_d;
         ack_q      <= ack_d;
         resp_vld_q <= resp_vld_d;
         rdy_q      <= rdy_d;
`ifdef SHOP_PORT_ARB_TIMEOUT_EN
         tmo_cnt_q  <= tmo_cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign bus.o_grant    = grant_q;
   assign bus.o_ack      = ack_q;
   assign bus.o_resp     = resp_q;
   assign bus.o_resp_vld = resp_vld_q;
   assign bus.o_shop_rdy = rdy_q;
   assign bus.o_shop_a   = shop_a_q;
   assign bus.o_shop_u   = shop_u_q;
endmodule

// File: tb/tb_shop_port_arb.sv
// Directed bench for shop_port_arb: reset, sessions, contention, abandon, timeout, reset mid-response.
// The shop model answers every token T with {16'hA5A5, T}.
module tb_shop_port_arb;
   localparam int NT = 4;
   localparam int AW = 56;
   localparam int OW = 72;
   localparam int UW = 4;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_pass;

   shop_port_arb_if #(.NUM_TERM(NT), .A_NUM_BITS(AW), .O_A_NUM_BITS(OW), .U_NUM_BITS(UW)) bus ();

   shop_port_arb #(
      .NUM_TERM(NT), .A_NUM_BITS(AW), .O_A_NUM_BITS(OW), .U_NUM_BITS(UW), .RESP_WAIT(2)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   assign bus.i_shop_a = {16'hA5A5, bus.o_shop_a};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full token exchange for owner t, starting in a WAIT_TOK cycle.
   task automatic do_token(input int t, input logic [AW-1:0] tok, input logic last);
      logic [NT-1:0] exp;
      exp = 4'b0001 << t;
      bus.i_valid[t]            = 1'b1;
      bus.i_last[t]             = last;
      bus.i_tok[t*AW +: AW]     = tok;
      tick();
      n_total++;
      if (bus.o_ack !== exp) $display("FAIL ack t%0d: got %b want %b", t, bus.o_ack, exp);
      else n_pass++;
      bus.i_valid[t] = 1'b0;
      bus.i_last[t]  = 1'b0;
      tick();
      n_total++;
      if (bus.o_shop_rdy !== 1'b1 || bus.o_shop_a !== tok || bus.o_ack !== 4'b0)
         $display("FAIL issue t%0d: rdy %b a %h ack %b want rdy 1 a %h ack 0", t, bus.o_shop_rdy, bus.o_shop_a, bus.o_ack, tok);
      else n_pass++;
      tick();
      n_total++;
      if (bus.o_shop_rdy !== 1'b0) $display("FAIL rdy_width t%0d: got %b want 0", t, bus.o_shop_rdy);
      else n_pass++;
      tick();
      n_total++;
      if (bus.o_resp_vld !== 4'b0) $display("FAIL resp_early t%0d: got %b want 0000", t, bus.o_resp_vld);
      else n_pass++;
      tick();
      n_total++;
      if (bus.o_resp_vld !== exp || bus.o_resp !== {16'hA5A5, tok})
         $display("FAIL resp t%0d: vld %b resp %h want vld %b resp %h", t, bus.o_resp_vld, bus.o_resp, exp, {16'hA5A5, tok});
      else n_pass++;
      n_total++;
      if (bus.o_grant !== (last ? 4'b0 : exp))
         $display("FAIL grant_after t%0d: got %b want %b", t, bus.o_grant, last ? 4'b0 : exp);
      else n_pass++;
      $display("token t%0d %h last=%0d resp=%h", t, tok, last, bus.o_resp);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.i_req   = 4'($urandom);
         bus.i_valid = 4'($urandom);
         bus.i_last  = 4'($urandom);
         bus.i_tok   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         tick();
      end
      n_total++;
      if ({bus.o_grant, bus.o_ack, bus.o_resp_vld, bus.o_timeout, bus.o_shop_rdy} !== 14'b0)
         $display("FAIL reset_ctl: got %h want 0", {bus.o_grant, bus.o_ack, bus.o_resp_vld, bus.o_timeout, bus.o_shop_rdy});
      else n_pass++;
      n_total++;
      if (bus.o_resp !== '0 || bus.o_shop_a !== '0 || bus.o_shop_u !== '0)
         $display("FAIL reset_data: resp %h a %h u %h want 0", bus.o_resp, bus.o_shop_a, bus.o_shop_u);
      else n_pass++;
      bus.i_req = '0; bus.i_valid = '0; bus.i_last = '0; bus.i_tok = '0;
      rst_n = 1'b1;
      tick();
      tick();
      n_total++;
      if (bus.o_grant !== 4'b0 || bus.o_shop_rdy !== 1'b0)
         $display("FAIL reset_idle: grant %b rdy %b want 0", bus.o_grant, bus.o_shop_rdy);
      else n_pass++;
      $display("reset done");
   endtask

   task automatic test_single_session();
      bus.i_req = 4'b0100;
      tick();
      n_total++;
      if (bus.o_grant !== 4'b0100 || bus.o_shop_u !== 4'd2)
         $display("FAIL single_grant: grant %b u %0d want 0100 u 2", bus.o_grant, bus.o_shop_u);
      else n_pass++;
      do_token(2, 56'("Login"), 1'b0);
      do_token(2, 56'("Adm"),   1'b0);
      do_token(2, 56'("123"),   1'b1);
      bus.i_req = '0;
      tick();
   endtask

   task automatic test_contention();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.i_req                = 4'b0011;
      bus.i_valid[1]           = 1'b1;
      bus.i_tok[1*AW +: AW]    = 56'("Xx");
      tick();
      n_total++;
      if (bus.o_grant !== 4'b0001) $display("FAIL cont_first: got %b want 0001", bus.o_grant);
      else n_pass++;
      do_token(0, 56'("Sel"), 1'b0);
      do_token(0, 56'("Buy"), 1'b1);
      tick();
      n_total++;
      if (bus.o_grant !== 4'b0010) $display("FAIL cont_second: got %b want 0010", bus.o_grant);
      else n_pass++;
      do_token(1, 56'("Qty"), 1'b1);
      tick();
      n_total++;
      if (bus.o_grant !== 4'b0001) $display("FAIL cont_wrap: got %b want 0001", bus.o_grant);
      else n_pass++;
      bus.i_req = '0;
      tick();
      n_total++;
      if (bus.o_grant !== 4'b0) $display("FAIL cont_drop: got %b want 0000", bus.o_grant);
      else n_pass++;
   endtask

   task automatic test_abandon();
      logic saw_rdy;
      bus.i_req = 4'b0010;
      tick();
      n_total++;
      if (bus.o_grant !== 4'b0010) $display("FAIL abandon_grant: got %b want 0010", bus.o_grant);
      else n_pass++;
      do_token(1, 56'("Hi"), 1'b0);
      bus.i_req = '0;
      tick();
      n_total++;
      if (bus.o_grant !== 4'b0 || bus.o_shop_rdy !== 1'b0)
         $display("FAIL abandon_rel: grant %b rdy %b want 0", bus.o_grant, bus.o_shop_rdy);
      else n_pass++;
      saw_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         saw_rdy = saw_rdy | bus.o_shop_rdy;
      end
      n_total++;
      if (saw_rdy !== 1'b0) $display("FAIL abandon_extra_rdy: got %b want 0", saw_rdy);
      else n_pass++;
      bus.i_req = 4'b0110;
      tick();
      n_total++;
      if (bus.o_grant !== 4'b0100) $display("FAIL abandon_ptr: got %b want 0100", bus.o_grant);
      else n_pass++;
      bus.i_req = '0;
      tick();
      tick();
   endtask

   task automatic test_timeout();
      logic bad;
      bus.i_req = 4'b1000;
      tick();
      n_total++;
      if (bus.o_grant !== 4'b1000) $display("FAIL tmo_grant: got %b want 1000", bus.o_grant);
      else n_pass++;
      bad = 1'b0;
`ifdef SHOP_PORT_ARB_TIMEOUT_EN
      for (int i = 0; i < 15; i++) begin
         tick();
         bad = bad | bus.o_timeout | (bus.o_grant !== 4'b1000);
      end
      n_total++;
      if (bad !== 1'b0) $display("FAIL tmo_early: got %b want 0", bad);
      else n_pass++;
      tick();
      n_total++;
      if (bus.o_timeout !== 1'b1 || bus.o_grant !== 4'b0)
         $display("FAIL tmo_fire: timeout %b grant %b want 1 0000", bus.o_timeout, bus.o_grant);
      else n_pass++;
      bus.i_req = '0;
      tick();
      n_total++;
      if (bus.o_timeout !== 1'b0) $display("FAIL tmo_pulse: got %b want 0", bus.o_timeout);
      else n_pass++;
      $display("timeout session forced release");
`else
      for (int i = 0; i < 110; i++) begin
         tick();
         bad = bad | bus.o_timeout | (bus.o_grant !== 4'b1000);
      end
      n_total++;
      if (bad !== 1'b0) $display("FAIL hold_session: got %b want 0", bad);
      else n_pass++;
      bus.i_req = '0;
      tick();
      n_total++;
      if (bus.o_grant !== 4'b0) $display("FAIL hold_release: got %b want 0000", bus.o_grant);
      else n_pass++;
      $display("idle session held 110 cycles");
`endif
      tick();
   endtask

   task automatic test_reset_mid_resp();
      logic saw_vld;
      bus.i_req = 4'b0010;
      tick();
      bus.i_req = '0;
      tick();
      bus.i_req = 4'b0100;
      tick();
      n_total++;
      if (bus.o_grant !== 4'b0100) $display("FAIL midrst_grant: got %b want 0100", bus.o_grant);
      else n_pass++;
      bus.i_valid[2]        = 1'b1;
      bus.i_tok[2*AW +: AW] = 56'("Pay");
      tick();
      bus.i_valid[2] = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({bus.o_grant, bus.o_shop_rdy, bus.o_resp_vld, bus.o_ack} !== 13'b0 || bus.o_shop_a !== '0)
         $display("FAIL midrst_clear: ctl %h a %h want 0", {bus.o_grant, bus.o_shop_rdy, bus.o_resp_vld, bus.o_ack}, bus.o_shop_a);
      else n_pass++;
      saw_vld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         saw_vld = saw_vld | (|bus.o_resp_vld);
      end
      n_total++;
      if (saw_vld !== 1'b0) $display("FAIL midrst_vld: got %b want 0", saw_vld);
      else n_pass++;
      rst_n     = 1'b1;
      bus.i_req = 4'b1001;
      tick();
      n_total++;
      if (bus.o_grant !== 4'b0001) $display("FAIL midrst_ptr: got %b want 0001", bus.o_grant);
      else n_pass++;
      bus.i_req = '0;
      tick();
   endtask

   initial begin
      n_total     = 0;
      n_pass      = 0;
      rst_n       = 1'b0;
      bus.i_req   = '0;
      bus.i_valid = '0;
      bus.i_last  = '0;
      bus.i_tok   = '0;
      test_reset();
      test_single_session();
      test_contention();
      test_abandon();
      test_timeout();
      test_reset_mid_resp();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
